instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Front-end sequencer that sits directly upstream of the execute datapath.
- Fetches one- and two-word instructions from instruction memory over a req/ack handshake and presents them on instr0/instr1.
- Drives current_state so the datapath asserts its write enables only during STATE_EXEC.
- Handles conditional skip (CND), branch redirection and halt.

Parameters:
- ADDR_W, 16, instruction word address width.
- RESET_PC, 16'h0000, first fetch address after reset.
- OP_LBSET, 8'h01, opcode of a two-word instruction (label set).
- OP_LIMM32, 8'h02, opcode of a two-word instruction (32-bit immediate).
- OP_CND, 8'h04, opcode of the conditional-skip prefix.
- OP_HALT, 8'hFF, opcode that stops the sequencer.

Ports:
- clk  in  1  system clock, all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request, held high until imem_ack.
- imem_addr  out  ADDR_W  word address of the fetch, stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr0  out  32  first instruction word.
- instr1  out  32  second word; 0 for one-word instructions.
- current_state  out  4  IDLE=0, FETCH0=1, FETCH1=2, EXEC=3, SKIP0=4, SKIP1=5, HALT=6.
- exec_hold  in  1  datapath extends EXEC (multi-cycle op); sampled only in EXEC.
- cnd_true  in  1  CND condition (ireg_d0[0]); sampled in the last EXEC cycle of a CND.
- branch_req  in  1  redirect request; sampled in the last EXEC cycle.
- branch_target  in  ADDR_W  new PC when branch_req=1.
- pc  out  ADDR_W  address of the next word to fetch.
- halted  out  1  high in HALT.

Behaviour:
- Reset (rst_n=0 at edge) forces the following, whatever the current state, including mid-handshake:
  - current_state=IDLE, pc=RESET_PC, instr0=0, instr1=0, imem_req=0, halted=0, skip_pending=0.
  - A late imem_ack after reset is ignored.
- IDLE: next cycle goes to FETCH0.
- FETCH0: imem_req=1, imem_addr=pc.
  - On imem_ack: latch rdata into instr0, clear instr1, pc <= pc+1.
  - If opcode rdata[31:24] is OP_LIMM32 or OP_LBSET, go to FETCH1; otherwise go to EXEC.
- FETCH1: imem_req=1, imem_addr=pc. On imem_ack: instr1 <= rdata, pc <= pc+1, go to EXEC.
- imem_req deasserts in the cycle after imem_ack. The minimum FETCH duration is 1 cycle (ack in the same cycle as req). There is no timeout.
- EXEC lasts exactly 1 cycle unless exec_hold=1. While held, current_state, instr0 and instr1 are frozen. The "last EXEC cycle" is the first cycle with exec_hold=0.
- Exits from the last EXEC cycle, in priority order:
  1. instr0 opcode OP_HALT -> HALT.
  2. branch_req=1 -> pc <= branch_target, go to FETCH0.
  3. opcode OP_CND and cnd_true=0 -> SKIP0.
  4. Otherwise -> FETCH0.
- CND with cnd_true=1 behaves as a NOP.
- SKIP0: fetch the word at pc without loading instr0. pc <= pc+1. If it is a two-word opcode go to SKIP1, else go to FETCH0. The skipped instruction never reaches EXEC.
- SKIP1: fetch and discard one word, pc <= pc+1, go to FETCH0.
- A CND word fetched during a skip is itself skipped; there is no chaining.
- HALT: no requests, halted=1. Exits only on reset.
- pc arithmetic is modulo 2^ADDR_W; fetching at pc=max wraps to 0.
- instr0 and instr1 change only on fetch acks or reset, never during EXEC.
- current_state is registered: no combinational path from any input to current_state or instr0/instr1.

Test Plan:
- One-word op, zero-latency memory:
  - After reset, mem[0]=32'h14_041000, ack in the same cycle as req -> states IDLE, FETCH0, EXEC, FETCH0; instr0=32'h14041000, instr1=0, pc=1 in EXEC.
- Two-word op with 3-cycle ack latency:
  - mem[0]=32'h02_050000, mem[1]=32'hDEADBEEF -> FETCH0 held 3 cycles, then FETCH1; in EXEC instr0=32'h02050000, instr1=32'hDEADBEEF, pc=2. imem_addr stays stable while req=1.
- CND false skips a two-word op:
  - mem[0]=CND, mem[1..2]=LIMM32 pair, mem[3]=OR; cnd_true=0 in EXEC -> SKIP0 at addr 1, SKIP1 at addr 2, then FETCH0 at addr 3. The next EXEC has instr0=mem[3].
  - With cnd_true=1, the next EXEC is the LIMM32 pair instead.
- Branch and exec_hold:
  - exec_hold=1 for 2 cycles, then branch_req=1 with branch_target=16'h0040 -> EXEC lasts 3 cycles with instr0 frozen; the next imem_addr is 16'h0040.
  - branch_req asserted while exec_hold=1 is ignored.
- Halt and reset mid-fetch:
  - OP_HALT reaches EXEC -> HALT with halted=1 and imem_req=0 for 20 cycles.
  - Separately, rst_n=0 in FETCH1 before ack -> next cycle IDLE, pc=RESET_PC, instr0=instr1=0. A stray ack one cycle later changes nothing.
- PC wrap:
  - RESET_PC=16'hFFFF, one-word op at FFFF -> pc=0 in EXEC, next fetch at 16'h0000.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//
// Front-end sequencer that sits directly upstream of the execute datapath.
// It fetches one- and two-word instructions from instruction memory over a
// req/ack handshake and presents them on instr0/instr1. The datapath uses
// current_state to enable its writes only during EXEC. Conditional skip
// (CND), branch redirection and halt are handled here.
//
// Handshake: imem_req is held high, with imem_addr stable, for the whole of
// a fetch state. The memory answers with a single-cycle imem_ack, and
// imem_rdata is valid in that same cycle. The ack may arrive in the first
// cycle of the request. imem_req drops in the cycle after the ack, unless
// the next state is another fetch. An imem_ack outside a fetch state is
// ignored.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/addr       fetch request and word address (addr == pc)
//   imem_ack/rdata      fetch acknowledge pulse and returned word
//   instr0/instr1       current instruction (instr1 = 0 for one-word ops)
//   current_state       FSM state (IDLE=0 .. HALT=6), registered
//   exec_hold           datapath stretches EXEC while high
//   cnd_true            CND condition, used in the last EXEC cycle
//   branch_req/target   redirect, used in the last EXEC cycle
//   pc                  address of the next word to fetch
//   halted              high while in HALT
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int               ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]       OP_LBSET  = 8'h01,
    parameter logic [7:0]       OP_LIMM32 = 8'h02,
    parameter logic [7:0]       OP_CND    = 8'h04,
    parameter logic [7:0]       OP_HALT   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr0,
    output logic [31:0]       instr1,
    output logic [3:0]        current_state,
    input  logic              exec_hold,
    input  logic              cnd_true,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_EXEC   = 4'd3,
        ST_SKIP0  = 4'd4,
        ST_SKIP1  = 4'd5,
        ST_HALT   = 4'd6
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr0_q, instr0_d;
    logic [31:0]       instr1_q, instr1_d;
    logic              req_q;
    logic              halted_q;

    logic [7:0]        rd_op;
    logic [7:0]        cur_op;
    logic              rd_two_word;
    logic [ADDR_W-1:0] pc_inc;

    assign rd_op       = imem_rdata[31:24];
    assign cur_op      = instr0_q[31:24];
    assign rd_two_word = (rd_op == OP_LIMM32) || (rd_op == OP_LBSET);
    // Natural wrap at 2^ADDR_W.
    assign pc_inc      = pc_q + ADDR_W'(1);

    // Next-state logic. instr0/instr1 only ever move on a fetch ack.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH0;
            ST_FETCH0: begin
                if (imem_ack) begin
                    instr0_d = imem_rdata;
                    instr1_d = '0;
                    pc_d     = pc_inc;
                    state_d  = rd_two_word ? ST_FETCH1 : ST_EXEC;
                end
            end
            ST_FETCH1: begin
                if (imem_ack) begin
                    instr1_d = imem_rdata;
                    pc_d     = pc_inc;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Inputs are only looked at in the last (un-held) EXEC cycle.
                if (!exec_hold) begin
                    if (cur_op == OP_HALT) begin
                        state_d = ST_HALT;
                    end else if (branch_req) begin
                        pc_d    = branch_target;
                        state_d = ST_FETCH0;
                    end else if ((cur_op == OP_CND) && !cnd_true) begin
                        state_d = ST_SKIP0;
                    end else begin
                        state_d = ST_FETCH0;
                    end
                end
            end
            ST_SKIP0: begin
                // The skipped word is consumed without touching instr0/1, so
                // a CND seen here is discarded like any other opcode.
                if (imem_ack) begin
                    pc_d    = pc_inc;
                    state_d = rd_two_word ? ST_SKIP1 : ST_FETCH0;
                end
            end
            ST_SKIP1: begin
                if (imem_ack) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single state register. Request and halted flags are registered from
    // the next state, so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr0_q <= '0;
            instr1_q <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            req_q    <= (state_d == ST_FETCH0) || (state_d == ST_FETCH1) ||
                        (state_d == ST_SKIP0)  || (state_d == ST_SKIP1);
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr0        = instr0_q;
    assign instr1        = instr1_q;
    assign current_state = state_q;
    assign pc            = pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//
// Per-cycle vector table for instr_fetch_seq. Each record holds the inputs
// applied for one cycle and the outputs expected during that cycle. Inputs
// change and outputs are checked on the falling edge. A second instance with
// RESET_PC=16'hFFFF covers pc wrap-around.
// ---------------------------------------------------------------------------
module tb_instr_fetch_seq;

    localparam logic [3:0] S_IDLE = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_EX = 4'd3,
                           S_SK0 = 4'd4, S_SK1 = 4'd5, S_HALT = 4'd6;

    localparam logic [31:0] W_ONE  = 32'h14041000;
    localparam logic [31:0] W_OR   = 32'h1A000005;
    localparam logic [31:0] W_CND  = 32'h04000000;
    localparam logic [31:0] W_LIM0 = 32'h02000011;
    localparam logic [31:0] W_LIM1 = 32'h00001234;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (RESET_PC = 0) ----------------
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr, pc, branch_target = '0;
    logic [31:0] imem_rdata = '0, instr0, instr1;
    logic [3:0]  current_state;
    logic        exec_hold = 1'b0, cnd_true = 1'b0, branch_req = 1'b0, halted;

    instr_fetch_seq dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr0(instr0), .instr1(instr1), .current_state(current_state),
        .exec_hold(exec_hold), .cnd_true(cnd_true),
        .branch_req(branch_req), .branch_target(branch_target),
        .pc(pc), .halted(halted)
    );

    // ---------------- DUT (RESET_PC = FFFF) ----------------
    logic        w_rst_n = 1'b0;
    logic        w_req, w_ack = 1'b0, w_halted;
    logic [15:0] w_addr, w_pc;
    logic [31:0] w_rdata = '0, w_i0, w_i1;
    logic [3:0]  w_state;

    instr_fetch_seq #(.RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr0(w_i0), .instr1(w_i1), .current_state(w_state),
        .exec_hold(1'b0), .cnd_true(1'b0),
        .branch_req(1'b0), .branch_target(16'h0000),
        .pc(w_pc), .halted(w_halted)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] rdata;
        logic        hold;
        logic        br;
        logic [15:0] tgt;
        logic        cnd;
        logic        chk;
        logic [3:0]  st;
        logic [15:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        req;
        logic        hlt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic h,
                                logic b, logic [15:0] t, logic c, logic k,
                                logic [3:0] s, logic [15:0] p, logic [31:0] x0,
                                logic [31:0] x1, logic q, logic hl);
        vec_t v;
        v.rst_n = r; v.ack = a; v.rdata = d; v.hold = h; v.br = b; v.tgt = t;
        v.cnd = c; v.chk = k; v.st = s; v.pc = p; v.i0 = x0; v.i1 = x1;
        v.req = q; v.hlt = hl;
        return v;
    endfunction

    // Reset cycle followed by the IDLE cycle it produces.
    task automatic add_reset();
        vq.push_back(mk(0,0,0,0,0,0,0,0, S_IDLE,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_IDLE,16'h0000,0,0,0,0));
    endtask

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cur_idx = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, cur_idx, act, exp);
        end
    endtask

    initial begin
        // One-word op, zero-latency memory.
        add_reset();
        vq.push_back(mk(1,1,W_ONE,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_EX,16'h0001,W_ONE,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0001,W_ONE,0,1,0));

        // Two-word op, ack on the third FETCH0 cycle.
        add_reset();
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,1,32'h02050000,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,1,32'hDEADBEEF,0,0,0,0,1, S_F1,16'h0001,32'h02050000,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_EX,16'h0002,32'h02050000,32'hDEADBEEF,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0002,32'h02050000,32'hDEADBEEF,1,0));

        // CND false: skip the LIMM32 pair, execute the OR.
        add_reset();
        vq.push_back(mk(1,1,W_CND,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_EX,16'h0001,W_CND,0,0,0));
        vq.push_back(mk(1,1,W_LIM0,0,0,0,0,1, S_SK0,16'h0001,W_CND,0,1,0));
        vq.push_back(mk(1,1,W_LIM1,0,0,0,0,1, S_SK1,16'h0002,W_CND,0,1,0));
        vq.push_back(mk(1,1,W_OR,0,0,0,0,1, S_F0,16'h0003,W_CND,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_EX,16'h0004,W_OR,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0004,W_OR,0,1,0));

        // CND true: behaves as NOP, LIMM32 pair executes.
        add_reset();
        vq.push_back(mk(1,1,W_CND,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,1,1, S_EX,16'h0001,W_CND,0,0,0));
        vq.push_back(mk(1,1,W_LIM0,0,0,0,0,1, S_F0,16'h0001,W_CND,0,1,0));
        vq.push_back(mk(1,1,W_LIM1,0,0,0,0,1, S_F1,16'h0002,W_LIM0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_EX,16'h0003,W_LIM0,W_LIM1,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0003,W_LIM0,W_LIM1,1,0));

        // Hold for 2 cycles (branch ignored), then branch to 0x0040.
        add_reset();
        vq.push_back(mk(1,1,W_OR,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,1,1,16'h0077,0,1, S_EX,16'h0001,W_OR,0,0,0));
        vq.push_back(mk(1,1,32'h99999999,1,1,16'h0077,0,1, S_EX,16'h0001,W_OR,0,0,0));
        vq.push_back(mk(1,0,0,0,1,16'h0040,0,1, S_EX,16'h0001,W_OR,0,0,0));
        vq.push_back(mk(1,1,W_ONE,0,0,0,0,1, S_F0,16'h0040,W_OR,0,1,0));
        // Branch held off by exec_hold, released with branch_req low.
        vq.push_back(mk(1,0,0,1,1,16'h0077,0,1, S_EX,16'h0041,W_ONE,0,0,0));
        vq.push_back(mk(1,0,0,0,0,16'h0077,0,1, S_EX,16'h0041,W_ONE,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0041,W_ONE,0,1,0));

        // HALT wins over a simultaneous branch, then stays put for 20 cycles.
        add_reset();
        vq.push_back(mk(1,1,32'hFF000000,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,1,16'h0040,0,1, S_EX,16'h0001,32'hFF000000,0,0,0));
        for (int k = 0; k < 20; k++)
            vq.push_back(mk(1,k[0],W_OR,0,1,16'h0040,0,1,
                            S_HALT,16'h0001,32'hFF000000,0,0,1));

        // Reset in FETCH1 before ack, then a stray ack while IDLE.
        add_reset();
        vq.push_back(mk(1,1,32'h01000000,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F1,16'h0001,32'h01000000,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, S_F1,16'h0001,32'h01000000,0,1,0));
        vq.push_back(mk(1,1,32'hCAFEF00D,0,0,0,0,1, S_IDLE,16'h0000,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, S_F0,16'h0000,0,0,1,0));

        // ---------------- apply table ----------------
        foreach (vq[i]) begin
            @(negedge clk);
            cur_idx       = i;
            rst_n         = vq[i].rst_n;
            imem_ack      = vq[i].ack;
            imem_rdata    = vq[i].rdata;
            exec_hold     = vq[i].hold;
            branch_req    = vq[i].br;
            branch_target = vq[i].tgt;
            cnd_true      = vq[i].cnd;
            if (vq[i].chk) begin
                check("state",  32'(current_state), 32'(vq[i].st));
                check("pc",     32'(pc),            32'(vq[i].pc));
                check("instr0", instr0,             vq[i].i0);
                check("instr1", instr1,             vq[i].i1);
                check("req",    32'(imem_req),      32'(vq[i].req));
                check("halted", 32'(halted),        32'(vq[i].hlt));
                if (vq[i].req)
                    check("addr", 32'(imem_addr), 32'(vq[i].pc));
            end
        end
        @(negedge clk);
        imem_ack = 1'b0;

        // ---------------- pc wrap (RESET_PC = FFFF) ----------------
        cur_idx = 1000;
        check("w_state_rst", 32'(w_state), 32'(S_IDLE));
        check("w_pc_rst",    32'(w_pc),    32'h0000FFFF);
        w_rst_n = 1'b1;
        @(negedge clk);
        cur_idx = 1001;
        check("w_state_f0",  32'(w_state), 32'(S_F0));
        check("w_addr_f0",   32'(w_addr),  32'h0000FFFF);
        check("w_req_f0",    32'(w_req),   32'd1);
        w_ack   = 1'b1;
        w_rdata = W_ONE;
        @(negedge clk);
        cur_idx = 1002;
        w_ack   = 1'b0;
        w_rdata = '0;
        check("w_state_ex",  32'(w_state), 32'(S_EX));
        check("w_pc_ex",     32'(w_pc),    32'h00000000);
        check("w_i0_ex",     w_i0,         W_ONE);
        @(negedge clk);
        cur_idx = 1003;
        check("w_state_f0b", 32'(w_state), 32'(S_F0));
        check("w_addr_f0b",  32'(w_addr),  32'h00000000);
        check("w_req_f0b",   32'(w_req),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
